tank_hit_judge: RTL

- Sits downstream of both per-player tank controllers.
- Consumes their tank and bullet positions plus bullet-active status.
- Once per frame, resolves bullet-vs-tank and tank-vs-tank collisions.
- Drives `bull_hit` and `can_move` back into each controller, keeps per-player scores, and sequences rounds (play, post-hit pause with tank reset, game over).

---
 rtl/tank_pkg.sv | 33 +++
 rtl/box_overlap.sv | 32 +++
 rtl/tank_hit_judge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pkg
// Brief    : Shared constants, codes and state type for the tank game judge.
// Revision : 1.0 - initial release
// ============================================================================
package tank_pkg;

    localparam int DEF_TANK_SIZE   = 32;
    localparam int DEF_BULLET_SIZE = 8;

    localparam logic [1:0] BULLET_NONE = 2'b00;
    localparam logic [1:0] BULLET_LIVE = 2'b01;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P0   = 2'b01;
    localparam logic [1:0] WINNER_P1   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Shared with the tank controllers
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        PAUSE     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/box_overlap.sv
`default_nettype none
// ============================================================================
// Module   : box_overlap
// Brief    : Inclusive axis-aligned overlap test of two square boxes.
// Revision : 1.0 - initial release
// ============================================================================
module box_overlap #(
    parameter int A_SIZE = 8,
    parameter int B_SIZE = 32
) (
    input  logic [9:0] i_ax,
    input  logic [9:0] i_ay,
    input  logic [9:0] i_bx,
    input  logic [9:0] i_by,
    output logic       o_overlap
);
    localparam logic [10:0] c_A = 11'(A_SIZE);
    localparam logic [10:0] c_B = 11'(B_SIZE);

    // One extra bit so that corner + size can never wrap
    logic [10:0] w_ax, w_ay, w_bx, w_by;

    assign w_ax = {1'b0, i_ax};
    assign w_ay = {1'b0, i_ay};
    assign w_bx = {1'b0, i_bx};
    assign w_by = {1'b0, i_by};

    assign o_overlap = (w_ax <= w_bx + c_B) && (w_bx <= w_ax + c_A) &&
                       (w_ay <= w_by + c_B) && (w_by <= w_ay + c_A);

endmodule
`default_nettype wire

// File: rtl/tank_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : tank_hit_judge
// Brief    : Per-frame bullet/tank collision judge, scoring and round FSM.
//            Optional BULLET_CANCEL_EN: colliding live bullets cancel out.
// Revision : 1.0 - initial release
// ============================================================================
module tank_hit_judge
    import tank_pkg::*;
#(
    parameter int TANK_SIZE    = DEF_TANK_SIZE,
    parameter int BULLET_SIZE  = DEF_BULLET_SIZE,
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] tank0_X,
    input  logic [9:0] tank0_Y,
    input  logic [9:0] tank1_X,
    input  logic [9:0] tank1_Y,
    input  logic [9:0] bullet0_X,
    input  logic [9:0] bullet0_Y,
    input  logic [9:0] bullet1_X,
    input  logic [9:0] bullet1_Y,
    input  logic [1:0] hit0,
    input  logic [1:0] hit1,
    output logic [1:0] bull_hit0,
    output logic [1:0] bull_hit1,
    output logic       can_move0,
    output logic       can_move1,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       round_reset,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int                 c_CNT_W    = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]         c_WIN      = 4'(WIN_SCORE);

    logic               r_frame_d, r_frame_rise;
    state_t             r_state, w_state_n;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_n;
    logic [3:0]         w_score0_n, w_score1_n, w_s0_inc, w_s1_inc;
    logic [1:0]         w_bh0_n, w_bh1_n, w_winner_n;
    logic               w_cm0_n, w_cm1_n, w_rr_n, w_go_n;
    logic               w_tanks_ovl, w_b0_t1, w_b1_t0, w_h0, w_h1, w_cancel;

    box_overlap #(.A_SIZE(TANK_SIZE), .B_SIZE(TANK_SIZE)) u_tank_tank (
        .i_ax(tank0_X), .i_ay(tank0_Y), .i_bx(tank1_X), .i_by(tank1_Y), .o_overlap(w_tanks_ovl)
    );
    box_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_b0_t1 (
        .i_ax(bullet0_X), .i_ay(bullet0_Y), .i_bx(tank1_X), .i_by(tank1_Y), .o_overlap(w_b0_t1)
    );
    box_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_b1_t0 (
        .i_ax(bullet1_X), .i_ay(bullet1_Y), .i_bx(tank0_X), .i_by(tank0_Y), .o_overlap(w_b1_t0)
    );

`ifdef BULLET_CANCEL_EN
    logic w_bullets_ovl;
    box_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(BULLET_SIZE)) u_b0_b1 (
        .i_ax(bullet0_X), .i_ay(bullet0_Y), .i_bx(bullet1_X), .i_by(bullet1_Y), .o_overlap(w_bullets_ovl)
    );
    assign w_cancel = (hit0 == BULLET_LIVE) && (hit1 == BULLET_LIVE) && w_bullets_ovl;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_h0     = (hit0 == BULLET_LIVE) && w_b0_t1;
    assign w_h1     = (hit1 == BULLET_LIVE) && w_b1_t0;
    assign w_s0_inc = (score0 >= c_WIN) ? score0 : score0 + 4'd1;
    assign w_s1_inc = (score1 >= c_WIN) ? score1 : score1 + 4'd1;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_score0_n = score0;
        w_score1_n = score1;
        w_bh0_n    = bull_hit0;
        w_bh1_n    = bull_hit1;
        w_cm0_n    = can_move0;
        w_cm1_n    = can_move1;
        w_rr_n     = round_reset;
        w_go_n     = game_over;
        w_winner_n = winner;
        case (r_state)
            PLAY: begin
                if (r_frame_rise) begin
                    w_cm0_n = ~w_tanks_ovl;
                    w_cm1_n = ~w_tanks_ovl;
                    if (w_cancel) begin
                        w_bh0_n = BULLET_NONE;
                        w_bh1_n = BULLET_NONE;
                    end else begin
                        w_bh0_n    = w_h0 ? BULLET_NONE : BULLET_LIVE;
                        w_bh1_n    = w_h1 ? BULLET_NONE : BULLET_LIVE;
                        w_score0_n = w_h0 ? w_s0_inc : score0;
                        w_score1_n = w_h1 ? w_s1_inc : score1;
                        if ((w_score0_n == c_WIN) || (w_score1_n == c_WIN)) begin
                            // Bit 0 flags player 0, bit 1 player 1; both set is a draw
                            w_state_n  = GAME_OVER;
                            w_rr_n     = 1'b1;
                            w_go_n     = 1'b1;
                            w_winner_n = {w_score1_n == c_WIN, w_score0_n == c_WIN};
                        end else if (w_h0 || w_h1) begin
                            w_state_n = PAUSE;
                            w_cnt_n   = c_CNT_LOAD;
                            w_rr_n    = 1'b1;
                        end
                    end
                end
            end
            PAUSE: begin
                w_rr_n  = 1'b1;
                w_bh0_n = BULLET_NONE;
                w_bh1_n = BULLET_NONE;
                w_cm0_n = 1'b1;
                w_cm1_n = 1'b1;
                if (r_frame_rise) begin
                    if (r_cnt == '0) begin
                        w_state_n = PLAY;
                        w_rr_n    = 1'b0;
                        w_bh0_n   = BULLET_LIVE;
                        w_bh1_n   = BULLET_LIVE;
                    end else begin
                        w_cnt_n = r_cnt - c_CNT_ONE;
                    end
                end
            end
            GAME_OVER: begin
                w_rr_n  = 1'b1;
                w_go_n  = 1'b1;
                w_bh0_n = BULLET_NONE;
                w_bh1_n = BULLET_NONE;
                if (restart) begin
                    w_state_n  = PLAY;
                    w_cnt_n    = '0;
                    w_score0_n = 4'd0;
                    w_score1_n = 4'd0;
                    w_bh0_n    = BULLET_LIVE;
                    w_bh1_n    = BULLET_LIVE;
                    w_cm0_n    = 1'b1;
                    w_cm1_n    = 1'b1;
                    w_rr_n     = 1'b0;
                    w_go_n     = 1'b0;
                    w_winner_n = WINNER_NONE;
                end
            end
            default: w_state_n = PLAY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_d    <= 1'b0;
            r_frame_rise <= 1'b0;
            r_state      <= PLAY;
            r_cnt        <= '0;
            score0       <= 4'd0;
            score1       <= 4'd0;
            bull_hit0    <= BULLET_LIVE;
            bull_hit1    <= BULLET_LIVE;
            can_move0    <= 1'b1;
            can_move1    <= 1'b1;
            round_reset  <= 1'b0;
            game_over    <= 1'b0;
            winner       <= WINNER_NONE;
        end else begin
            r_frame_d    <= frame_clk;
            r_frame_rise <= frame_clk & ~r_frame_d;
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            score0       <= w_score0_n;
            score1       <= w_score1_n;
            bull_hit0    <= w_bh0_n;
            bull_hit1    <= w_bh1_n;
            can_move0    <= w_cm0_n;
            can_move1    <= w_cm1_n;
            round_reset  <= w_rr_n;
            game_over    <= w_go_n;
            winner       <= w_winner_n;
        end
    end

endmodule
`default_nettype wire
